dp_snapshot_tx: RTL and testbench
=================================

# dp_snapshot_tx

Snapshot serializer between the MIPS datapath debug bus and the UART transmitter. On a snapshot request it latches the datapath bus in one cycle, then sends it as a framed byte stream through the UART `tx_start`/`tx_done` handshake:

- one header byte;
- the payload bytes, MSB byte first;
- one checksum byte.

It owns the UART TX resource for the duration of the frame and signals completion to the debug controller.

## Interface

Parameters:
- `BUS_BYTES`, default 3: payload length in bytes. The datapath bus is `8*BUS_BYTES` bits wide. Legal range is 1..255.
- `HDR_BYTE`, default 8'hA5: frame header byte.

Ports:
- `clk`  in  1: single clock. All logic is rising-edge.
- `rst`  in  1: reset, synchronous and active-high.
- `snap_req`  in  1: snapshot request, single-cycle pulse. Only accepted in IDLE.
- `dp_bus`  in  `8*BUS_BYTES`: datapath debug bus. Sampled only in the accept cycle.
- `tx_done`  in  1: UART byte-sent pulse.
- `tx_start`  out  1: UART send strobe, one cycle per byte.
- `tx_data`  out  8: byte to transmit.
- `busy`  out  1: frame in progress.
- `snap_done`  out  1: one-cycle pulse when the frame is complete.

## Operation

State machine states: IDLE, SEND, WAIT.

- **IDLE**
  - On `snap_req`: latch `dp_bus` into the shadow register, set `idx=0`, clear `csum`, go to SEND.
  - `tx_done` is ignored in IDLE.
- **SEND** (exactly one cycle)
  - Assert `tx_start`.
  - Drive `tx_data` from `idx`:
    - `idx=0`: `HDR_BYTE`.
    - `idx=1..BUS_BYTES`: shadow byte `BUS_BYTES-idx` (MSB byte first).
    - `idx=BUS_BYTES+1`: `csum`.
  - Go to WAIT.
- **WAIT**
  - On `tx_done`:
    - If the byte just sent was a payload byte, update `csum` with it.
    - If `idx==BUS_BYTES+1`: go to IDLE and pulse `snap_done`.
    - Otherwise: increment `idx` and go to SEND.
- **Checksum:** 8-bit modulo-256 sum of the payload bytes only. The header is excluded and carries wrap silently.
- **Frame length:** `BUS_BYTES+2` bytes.
- **`idx` width:** 9 bits, so that `BUS_BYTES=255` does not wrap.
- **Shadow register:** frozen for the whole frame. Changes on `dp_bus` after accept do not alter the frame.
- **`snap_req` while `busy`:** dropped. It is not queued.

## Timing

- **Reset values:** `tx_start=0`, `tx_data=8'h00`, `busy=0`, `snap_done=0`. State is IDLE; `idx`, `csum` and the shadow register are cleared.
- **Reset mid-frame:** the next cycle is IDLE with all outputs at reset values. No partial-frame `snap_done` is produced.
- **Request latency:** `snap_req` high at cycle n → `tx_start` high and header on `tx_data` at n+1.
- **`tx_data` hold:** registered, and stable from the `tx_start` cycle until the cycle after the matching `tx_done`.
- **`tx_done` timing:**
  - `tx_done` in the same cycle as `tx_start` (the SEND cycle) is ignored.
  - `tx_done` at cycle m in WAIT → next `tx_start` at m+1.
- **Frame end:** final `tx_done` at cycle m → `snap_done=1` and `busy=0` at m+1.
  - A `snap_req` at m+1 is accepted, giving `tx_start` at m+2.
- **`busy`:** high from the cycle after accept through the final WAIT.
- **Outputs:** all are registered, with no combinational path from inputs.
- **Minimum frame duration:** `2*(BUS_BYTES+2)` cycles with `tx_done` returned immediately.

## Structure

- **Shared package `dbg_pkg`:**
  - state encoding constants `ST_IDLE=2'd0`, `ST_SEND=2'd1`, `ST_WAIT=2'd2`;
  - default header constant `DBG_HDR=8'hA5`.
- **Sub-module:** none. Byte selection is a single indexed part-select inside the block.
- **Expected size:** one FSM plus a datapath of roughly 150 lines.

## Test plan

- **Basic frame:** `BUS_BYTES=3`, `dp_bus=24'h616263`, pulse `snap_req`, and answer each `tx_start` with `tx_done` 5 cycles later.
  - Required bytes in order: A5, 61, 62, 63, 26.
  - `snap_done` pulses once.
  - `busy` is low the same cycle `snap_done` goes high.
- **Frozen payload:** change `dp_bus` to 24'hFFFFFF one cycle after accept. The frame is still A5 61 62 63 26.
- **Request while busy:** pulse `snap_req` during the third byte's WAIT.
  - Exactly one frame is sent (5 `tx_start` pulses).
  - Exactly one `snap_done`.
- **Checksum wrap:** `dp_bus=24'hFFFF02` → frame A5 FF FF 02 00.
- **Reset mid-frame:** assert `rst` in the WAIT after the second byte.
  - `tx_start`, `busy` and `snap_done` are 0 next cycle, with no `snap_done` for the aborted frame.
  - A subsequent `snap_req` produces a full fresh frame starting with A5.
- **Back-to-back and early `tx_done`:**
  - `tx_done` coincident with `tx_start` is ignored (the FSM stays waiting).
  - `snap_req` in the `snap_done` cycle starts a new frame with the header at the next cycle.

Source files
------------

// File: rtl/dbg_pkg.sv
// rtl/dbg_pkg.sv - shared debug-path constants and state encoding
package dbg_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    localparam logic [7:0] DBG_HDR = 8'hA5;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_SEND = ST_SEND,
        S_WAIT = ST_WAIT
    } snap_state_t;

endpackage

// File: rtl/dp_snapshot_tx.sv
// rtl/dp_snapshot_tx.sv - datapath snapshot framer feeding the UART transmitter
module dp_snapshot_tx
    import dbg_pkg::*;
#(
    parameter int         BUS_BYTES = 3,
    parameter logic [7:0] HDR_BYTE  = DBG_HDR
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   snap_req,
    input  logic [8*BUS_BYTES-1:0] dp_bus,
    input  logic                   tx_done,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    output logic                   busy,
    output logic                   snap_done
);

    localparam int         W        = 8 * BUS_BYTES;
    localparam logic [8:0] LAST_IDX = 9'(BUS_BYTES + 1);

    snap_state_t    state_q, state_d;
    logic [W-1:0]   shadow_q, shadow_d;
    logic [8:0]     idx_q, idx_d;
    logic [7:0]     csum_q, csum_d;
    logic           tx_start_q, tx_start_d;
    logic [7:0]     tx_data_q, tx_data_d;
    logic           busy_q, busy_d;
    logic           snap_done_q, snap_done_d;
    logic [7:0]     csum_nxt;
    logic [8:0]     idx_inc;

    function automatic logic is_payload(input logic [8:0] k);
        return (k >= 9'd1) && (k <= 9'(BUS_BYTES));
    endfunction

    // Index 1 is the most significant byte of the shadow register.
    function automatic logic [7:0] payload_byte(input logic [W-1:0] sh, input logic [8:0] k);
        int off;
        off = 0;
        if (is_payload(k))
            off = (BUS_BYTES - int'(k)) * 8;
        return sh[off +: 8];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            shadow_q    <= '0;
            idx_q       <= '0;
            csum_q      <= '0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            busy_q      <= 1'b0;
            snap_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            idx_q       <= idx_d;
            csum_q      <= csum_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            busy_q      <= busy_d;
            snap_done_q <= snap_done_d;
        end
    end

    // Outputs are computed one cycle ahead so every port is a flop.
    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        idx_d       = idx_q;
        csum_d      = csum_q;
        tx_start_d  = 1'b0;
        tx_data_d   = tx_data_q;
        busy_d      = busy_q;
        snap_done_d = 1'b0;
        idx_inc     = idx_q + 9'd1;
        csum_nxt    = csum_q + (is_payload(idx_q) ? payload_byte(shadow_q, idx_q) : 8'h00);

        case (state_q)
            S_IDLE: begin
                if (snap_req) begin
                    shadow_d   = dp_bus;
                    idx_d      = '0;
                    csum_d     = '0;
                    tx_start_d = 1'b1;
                    tx_data_d  = HDR_BYTE;
                    busy_d     = 1'b1;
                    state_d    = S_SEND;
                end
            end
            S_SEND: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (tx_done) begin
                    csum_d = csum_nxt;
                    if (idx_q == LAST_IDX) begin
                        snap_done_d = 1'b1;
                        busy_d      = 1'b0;
                        state_d     = S_IDLE;
                    end else begin
                        idx_d      = idx_inc;
                        tx_start_d = 1'b1;
                        tx_data_d  = (idx_inc == LAST_IDX) ? csum_nxt
                                                           : payload_byte(shadow_q, idx_inc);
                        state_d    = S_SEND;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign tx_start  = tx_start_q;
    assign tx_data   = tx_data_q;
    assign busy      = busy_q;
    assign snap_done = snap_done_q;

endmodule

// File: tb/tb_dp_snapshot_tx.sv
// tb/tb_dp_snapshot_tx.sv - directed self-checking bench for dp_snapshot_tx
module tb_dp_snapshot_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        snap_req = 1'b0;
    logic [23:0] dp_bus = 24'h0;
    logic        manual_done = 1'b0;
    logic        auto_done = 1'b0;
    logic        tx_done;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        busy;
    logic        snap_done;

    int checks = 0;
    int failures = 0;
    int starts = 0;
    int dones = 0;
    int hold_err = 0;
    int cyc = 0;
    int done_cyc = 0;
    int cnt = 0;
    int dly = 5;
    bit auto_en = 1'b1;
    bit done_busy = 1'b0;
    bit hold_active = 1'b0;
    logic [7:0] held = 8'h00;
    logic       cur_done;
    logic [7:0] bytes[$];

    assign tx_done = auto_done | manual_done;

    dp_snapshot_tx #(.BUS_BYTES(3), .HDR_BYTE(8'hA5)) dut (
        .clk       (clk),
        .rst       (rst),
        .snap_req  (snap_req),
        .dp_bus    (dp_bus),
        .tx_done   (tx_done),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .busy      (busy),
        .snap_done (snap_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Byte logger, tx_data hold checker and delayed tx_done responder.
    always @(negedge clk) begin
        cur_done = tx_done;
        if (tx_start) begin
            bytes.push_back(tx_data);
            starts = starts + 1;
            held = tx_data;
            hold_active = 1'b1;
        end else if (hold_active && busy) begin
            if (tx_data !== held) hold_err = hold_err + 1;
            if (cur_done) hold_active = 1'b0;
        end
        if (!busy && !tx_start) hold_active = 1'b0;
        if (snap_done) begin
            dones = dones + 1;
            done_busy = busy;
            done_cyc = cyc;
        end
        auto_done = 1'b0;
        if (cnt > 0) begin
            cnt = cnt - 1;
            if (cnt == 0) auto_done = 1'b1;
        end
        if (tx_start && auto_en) cnt = dly;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic clear_log;
        bytes.delete();
        starts = 0;
        dones = 0;
        hold_err = 0;
    endtask

    function automatic logic [39:0] pack5(input int base);
        logic [39:0] v;
        v = '0;
        for (int i = 0; i < 5; i++)
            if (base + i < bytes.size()) v = {v[31:0], bytes[base + i]};
            else v = {v[31:0], 8'hXX};
        return v;
    endfunction

    task automatic wait_done(input int base, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (dones > base) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_starts(input int n);
        for (int i = 0; i < 200 && starts < n; i++) tick();
    endtask

    task automatic test_reset;
        checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL rst_tx_start got=%b exp=0", tx_start); end
        checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL rst_tx_data got=%h exp=00", tx_data); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (snap_done !== 1'b0) begin failures++; $display("FAIL rst_snap_done got=%b exp=0", snap_done); end
    endtask

    task automatic test_basic;
        bit ok;
        clear_log(); auto_en = 1; dly = 5; dp_bus = 24'h616263;
        snap_req = 1; tick(); snap_req = 0;
        checks++; if ({tx_start, tx_data, busy} !== {1'b1, 8'hA5, 1'b1}) begin failures++;
            $display("FAIL basic_latency got start=%b data=%h busy=%b exp 1 a5 1", tx_start, tx_data, busy); end
        wait_done(0, ok);
        checks++; if (!ok) begin failures++; $display("FAIL basic_timeout got no snap_done exp snap_done"); end
        repeat (12) tick();
        checks++; if (bytes.size() != 5 || pack5(0) !== 40'hA561626326) begin failures++;
            $display("FAIL basic_bytes got n=%0d %h exp n=5 a561626326", bytes.size(), pack5(0)); end
        checks++; if (dones != 1) begin failures++; $display("FAIL basic_done_count got=%0d exp=1", dones); end
        checks++; if (done_busy !== 1'b0) begin failures++; $display("FAIL basic_busy_at_done got=%b exp=0", done_busy); end
        checks++; if (hold_err != 0) begin failures++; $display("FAIL basic_data_hold got=%0d exp=0", hold_err); end
    endtask

    task automatic test_frozen;
        bit ok;
        clear_log(); dp_bus = 24'h616263;
        snap_req = 1; tick(); snap_req = 0; dp_bus = 24'hFFFFFF;
        wait_done(0, ok);
        checks++; if (!ok || bytes.size() != 5 || pack5(0) !== 40'hA561626326) begin failures++;
            $display("FAIL frozen_bytes got n=%0d %h exp n=5 a561626326", bytes.size(), pack5(0)); end
    endtask

    task automatic test_req_while_busy;
        bit ok;
        clear_log(); dp_bus = 24'h616263;
        snap_req = 1; tick(); snap_req = 0;
        wait_starts(3);
        tick();
        snap_req = 1; tick(); snap_req = 0;
        wait_done(0, ok);
        repeat (25) tick();
        checks++; if (starts != 5) begin failures++; $display("FAIL busy_req_starts got=%0d exp=5", starts); end
        checks++; if (dones != 1) begin failures++; $display("FAIL busy_req_dones got=%0d exp=1", dones); end
        checks++; if (pack5(0) !== 40'hA561626326) begin failures++;
            $display("FAIL busy_req_bytes got=%h exp=a561626326", pack5(0)); end
    endtask

    task automatic test_csum_wrap;
        bit ok;
        clear_log(); dp_bus = 24'hFFFF02;
        snap_req = 1; tick(); snap_req = 0;
        wait_done(0, ok);
        checks++; if (!ok || bytes.size() != 5 || pack5(0) !== 40'hA5FFFF0200) begin failures++;
            $display("FAIL wrap_bytes got n=%0d %h exp n=5 a5ffff0200", bytes.size(), pack5(0)); end
    endtask

    task automatic test_reset_mid;
        bit ok;
        clear_log(); dp_bus = 24'h010203;
        snap_req = 1; tick(); snap_req = 0;
        wait_starts(2);
        tick();
        rst = 1; tick(); rst = 0;
        checks++; if ({tx_start, busy, snap_done, tx_data} !== {3'b000, 8'h00}) begin failures++;
            $display("FAIL midrst_outputs got start=%b busy=%b done=%b data=%h exp 0 0 0 00",
                     tx_start, busy, snap_done, tx_data); end
        repeat (12) tick();
        checks++; if (dones != 0) begin failures++; $display("FAIL midrst_no_done got=%0d exp=0", dones); end
        clear_log();
        snap_req = 1; tick(); snap_req = 0;
        checks++; if ({tx_start, tx_data} !== {1'b1, 8'hA5}) begin failures++;
            $display("FAIL midrst_restart got start=%b data=%h exp 1 a5", tx_start, tx_data); end
        wait_done(0, ok);
        checks++; if (!ok || bytes.size() != 5 || pack5(0) !== 40'hA501020306) begin failures++;
            $display("FAIL midrst_bytes got n=%0d %h exp n=5 a501020306", bytes.size(), pack5(0)); end
    endtask

    task automatic test_back_to_back;
        bit ok;
        int c;
        repeat (10) tick();
        clear_log(); auto_en = 0; dp_bus = 24'h616263;
        snap_req = 1; tick(); snap_req = 0;
        manual_done = 1; tick(); manual_done = 0;
        repeat (3) tick();
        checks++; if (starts != 1 || busy !== 1'b1) begin failures++;
            $display("FAIL early_done_ignored got starts=%0d busy=%b exp 1 1", starts, busy); end
        auto_en = 1; dly = 1;
        manual_done = 1; tick(); manual_done = 0;
        wait_done(0, ok);
        c = cyc;
        snap_req = 1; tick(); snap_req = 0;
        checks++; if ({tx_start, tx_data} !== {1'b1, 8'hA5}) begin failures++;
            $display("FAIL b2b_header got start=%b data=%h exp 1 a5", tx_start, tx_data); end
        wait_done(1, ok);
        checks++; if (!ok || done_cyc - c != 11) begin failures++;
            $display("FAIL b2b_duration got=%0d exp=11", done_cyc - c); end
        repeat (5) tick();
        checks++; if (bytes.size() != 10 || dones != 2 || pack5(0) !== 40'hA561626326 || pack5(5) !== 40'hA561626326) begin
            failures++;
            $display("FAIL b2b_frames got n=%0d dones=%0d %h %h exp n=10 dones=2 a561626326 a561626326",
                     bytes.size(), dones, pack5(0), pack5(5)); end
    endtask

    initial begin
        rst = 1;
        tick(); tick();
        test_reset();
        rst = 0;
        tick();
        test_basic();
        test_frozen();
        test_req_while_busy();
        test_csum_wrap();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
